hazard_scoreboard: RTL and testbench

- Parametrised hazard unit for the five-stage MIPS pipeline; replaces per-stage instruction decode with an internal E/M/W destination scoreboard.
- Decode supplies register addresses and Tuse/Tnew. The block tracks each in-flight write as it ages, and produces stall and forwarding selects for D, E and M.
- Optionally tracks a multi-cycle multiply/divide unit and stalls MDU instructions while it is busy.

---
 rtl/hazard_scoreboard.sv | 171 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: five-stage MIPS hazard unit built around an E/M/W
// destination scoreboard. Decode supplies register addresses plus Tuse/Tnew.
// The block produces the stall and the forwarding selects for D, E and M.
// Optional multiply/divide busy tracking is compiled in with `define HAZARD_MDU_EN.
module hazard_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int T_W      = 3,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] d_rs,
  input  logic [ADDR_W-1:0] d_rt,
  input  logic [T_W-1:0]    d_tuse_rs,
  input  logic [T_W-1:0]    d_tuse_rt,
  input  logic [ADDR_W-1:0] d_a3,
  input  logic [T_W-1:0]    d_tnew,
  input  logic              d_md,
  input  logic              d_md_start,
  input  logic              d_md_div,
  output logic              stall,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic [1:0]        fwd_m_rt,
  output logic              md_busy
);

  localparam logic [T_W-1:0] TUSE_NONE = {T_W{1'b1}};
  localparam logic [1:0]     SRC_NONE  = 2'd0;
  localparam logic [1:0]     SRC_E     = 2'd1;
  localparam logic [1:0]     SRC_M     = 2'd2;
  localparam logic [1:0]     SRC_W     = 2'd3;

  // Scoreboard slots. M keeps only rt because store data is the only
  // operand still read in M; W keeps no sources at all.
  logic [ADDR_W-1:0] e_a3, e_rs, e_rt;
  logic [T_W-1:0]    e_tnew;
  logic [ADDR_W-1:0] m_a3, m_rt;
  logic [T_W-1:0]    m_tnew;
  logic [ADDR_W-1:0] w_a3;
  logic [T_W-1:0]    w_tnew;

  logic data_stall;
  logic md_stall;

  // One stage older means one cycle closer to the result; never below zero.
  function automatic logic [T_W-1:0] age_tnew(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // Operand r needs a value that a slot will not have in time.
  function automatic logic waits_on(input logic [ADDR_W-1:0] r,
                                    input logic [T_W-1:0]    tuse,
                                    input logic [ADDR_W-1:0] a3,
                                    input logic [T_W-1:0]    tnew);
    return (r != '0) && (r == a3) && (tnew > tuse);
  endfunction

  // Operand r can be taken from a slot right now.
  function automatic logic ready_from(input logic [ADDR_W-1:0] r,
                                      input logic [ADDR_W-1:0] a3,
                                      input logic [T_W-1:0]    tnew);
    return (r != '0) && (r == a3) && (tnew == '0);
  endfunction

  // Age the scoreboard every edge; a stalled D instruction leaves a bubble in E.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_a3   <= '0;
      e_rs   <= '0;
      e_rt   <= '0;
      e_tnew <= '0;
      m_a3   <= '0;
      m_rt   <= '0;
      m_tnew <= '0;
      w_a3   <= '0;
      w_tnew <= '0;
    end else begin
      w_a3   <= m_a3;
      w_tnew <= age_tnew(m_tnew);
      m_a3   <= e_a3;
      m_rt   <= e_rt;
      m_tnew <= age_tnew(e_tnew);
      if (stall) begin
        e_a3   <= '0;
        e_rs   <= '0;
        e_rt   <= '0;
        e_tnew <= '0;
      end else begin
        e_a3   <= d_a3;
        e_rs   <= d_rs;
        e_rt   <= d_rt;
        e_tnew <= d_tnew;
      end
    end
  end

  // Data stall: a read operand waits on a result still being produced in E or M.
  always_comb begin
    data_stall = 1'b0;
    if (d_tuse_rs != TUSE_NONE) begin
      data_stall = data_stall
                 | waits_on(d_rs, d_tuse_rs, e_a3, e_tnew)
                 | waits_on(d_rs, d_tuse_rs, m_a3, m_tnew);
    end
    if (d_tuse_rt != TUSE_NONE) begin
      data_stall = data_stall
                 | waits_on(d_rt, d_tuse_rt, e_a3, e_tnew)
                 | waits_on(d_rt, d_tuse_rt, m_a3, m_tnew);
    end
  end

  // Forwarding selects, youngest ready producer first.
  always_comb begin
    fwd_d_rs = SRC_NONE;
    fwd_d_rt = SRC_NONE;
    fwd_e_rs = SRC_NONE;
    fwd_e_rt = SRC_NONE;
    fwd_m_rt = SRC_NONE;

    if (ready_from(d_rs, e_a3, e_tnew))      fwd_d_rs = SRC_E;
    else if (ready_from(d_rs, m_a3, m_tnew)) fwd_d_rs = SRC_M;
    else if (ready_from(d_rs, w_a3, w_tnew)) fwd_d_rs = SRC_W;

    if (ready_from(d_rt, e_a3, e_tnew))      fwd_d_rt = SRC_E;
    else if (ready_from(d_rt, m_a3, m_tnew)) fwd_d_rt = SRC_M;
    else if (ready_from(d_rt, w_a3, w_tnew)) fwd_d_rt = SRC_W;

    if (ready_from(e_rs, m_a3, m_tnew))      fwd_e_rs = SRC_M;
    else if (ready_from(e_rs, w_a3, w_tnew)) fwd_e_rs = SRC_W;

    if (ready_from(e_rt, m_a3, m_tnew))      fwd_e_rt = SRC_M;
    else if (ready_from(e_rt, w_a3, w_tnew)) fwd_e_rt = SRC_W;

    if (ready_from(m_rt, w_a3, w_tnew))      fwd_m_rt = SRC_W;
  end

  assign stall = data_stall | md_stall;

`ifdef HAZARD_MDU_EN
  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

  logic [CNT_W-1:0] md_cnt;

  // MDU busy counter: loads only on a start that actually issues, then drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (d_md_start && !stall) begin
      md_cnt <= d_md_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  assign md_busy  = (md_cnt != '0);
  assign md_stall = d_md && md_busy;
`else
  logic unused_md_inputs;
  assign unused_md_inputs = d_md ^ d_md_start ^ d_md_div;
  assign md_busy  = 1'b0;
  assign md_stall = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table, hand-written multi-cycle
// sequences and randomized traffic for hazard_scoreboard, checked against an
// age-based model of in-flight instructions.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam int U      = 7;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [2:0] tuse_rs;
    logic [2:0] tuse_rt;
    logic [4:0] a3;
    logic [2:0] tnew;
    logic       md;
    logic       md_start;
    logic       md_div;
  } din_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] fd_rs;
    logic [1:0] fd_rt;
    logic [1:0] fe_rs;
    logic [1:0] fe_rt;
    logic [1:0] fm_rt;
    logic       busy;
  } dout_t;

  typedef struct packed {
    din_t  d;
    dout_t e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md, d_md_start, d_md_div;
  logic       stall, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

  int n_vec = 0;
  int n_miscompare = 0;

  // Model: index 0 = E, 1 = M, 2 = W; tnew kept as issued, age is the index.
  int mdl_a3[3];
  int mdl_rs[3];
  int mdl_rt[3];
  int mdl_tnew[3];
  int mdl_cycle = 0;
  int mdl_busy_until = -1;

  vec_t tbl[36];

  hazard_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_a3       (d_a3),
    .d_tnew     (d_tnew),
    .d_md       (d_md),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .stall      (stall),
    .fwd_d_rs   (fwd_d_rs),
    .fwd_d_rt   (fwd_d_rt),
    .fwd_e_rs   (fwd_e_rs),
    .fwd_e_rt   (fwd_e_rt),
    .fwd_m_rt   (fwd_m_rt),
    .md_busy    (md_busy)
  );

  // 20 ns clock
  always #10 clk = ~clk;

  function automatic din_t mk_in(input int rs, input int rt, input int tu_rs,
                                 input int tu_rt, input int a3, input int tnew);
    din_t d;
    d = '0;
    d.rs = 5'(rs);
    d.rt = 5'(rt);
    d.tuse_rs = 3'(tu_rs);
    d.tuse_rt = 3'(tu_rt);
    d.a3 = 5'(a3);
    d.tnew = 3'(tnew);
    return d;
  endfunction

  function automatic din_t nop_in();
    return mk_in(0, 0, U, U, 0, 0);
  endfunction

  function automatic din_t md_in(input int start, input int div, input int a3, input int tnew);
    din_t d;
    d = mk_in(0, 0, U, U, a3, tnew);
    d.md = 1'b1;
    d.md_start = 1'(start);
    d.md_div = 1'(div);
    return d;
  endfunction

  function automatic dout_t mk_out(input int st, input int fdrs, input int fdrt,
                                   input int fers, input int fert, input int fmrt,
                                   input int busy);
    dout_t o;
    o.stall = 1'(st);
    o.fd_rs = 2'(fdrs);
    o.fd_rt = 2'(fdrt);
    o.fe_rs = 2'(fers);
    o.fe_rt = 2'(fert);
    o.fm_rt = 2'(fmrt);
    o.busy  = 1'(busy);
    return o;
  endfunction

  function automatic vec_t mk(input int rs, input int rt, input int tu_rs, input int tu_rt,
                              input int a3, input int tnew, input int st, input int fdrs,
                              input int fdrt, input int fers, input int fert, input int fmrt);
    vec_t v;
    v.d = mk_in(rs, rt, tu_rs, tu_rt, a3, tnew);
    v.e = mk_out(st, fdrs, fdrt, fers, fert, fmrt, 0);
    return v;
  endfunction

  // Cycles still needed by the instruction sitting at age k.
  function automatic int remaining(input int k);
    return (mdl_tnew[k] > k) ? mdl_tnew[k] - k : 0;
  endfunction

  function automatic bit ready(input int k, input int r);
    return (r != 0) && (mdl_a3[k] == r) && (remaining(k) == 0);
  endfunction

  function automatic bit must_wait(input int r, input int tuse);
    bit w;
    w = 1'b0;
    if (r != 0 && tuse != U)
      for (int k = 0; k < 2; k++)
        if (mdl_a3[k] == r && remaining(k) > tuse) w = 1'b1;
    return w;
  endfunction

  // Youngest ready stage at or after first_age; result code is age + 1.
  function automatic logic [1:0] source(input int r, input int first_age);
    for (int k = first_age; k < 3; k++)
      if (ready(k, r)) return 2'(k + 1);
    return 2'd0;
  endfunction

  function automatic dout_t model_eval(input din_t d);
    dout_t o;
    o = '0;
    o.stall = must_wait(int'(d.rs), int'(d.tuse_rs)) | must_wait(int'(d.rt), int'(d.tuse_rt));
`ifdef HAZARD_MDU_EN
    o.busy = (mdl_cycle <= mdl_busy_until);
    if (d.md && o.busy) o.stall = 1'b1;
`endif
    o.fd_rs = source(int'(d.rs), 0);
    o.fd_rt = source(int'(d.rt), 0);
    o.fe_rs = source(mdl_rs[0], 1);
    o.fe_rt = source(mdl_rt[0], 1);
    o.fm_rt = source(mdl_rt[1], 2);
    return o;
  endfunction

  task automatic model_step(input din_t d, input logic st);
    for (int k = 2; k > 0; k--) begin
      mdl_a3[k] = mdl_a3[k-1];
      mdl_rs[k] = mdl_rs[k-1];
      mdl_rt[k] = mdl_rt[k-1];
      mdl_tnew[k] = mdl_tnew[k-1];
    end
    mdl_a3[0]   = st ? 0 : int'(d.a3);
    mdl_rs[0]   = st ? 0 : int'(d.rs);
    mdl_rt[0]   = st ? 0 : int'(d.rt);
    mdl_tnew[0] = st ? 0 : int'(d.tnew);
`ifdef HAZARD_MDU_EN
    if (d.md_start && !st) mdl_busy_until = mdl_cycle + (d.md_div ? DIV_N : MULT_N);
`endif
    mdl_cycle++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mdl_a3[k] = 0;
      mdl_rs[k] = 0;
      mdl_rt[k] = 0;
      mdl_tnew[k] = 0;
    end
    mdl_busy_until = -1;
  endtask

  task automatic apply_stimulus(input din_t d);
    d_rs       = d.rs;
    d_rt       = d.rt;
    d_tuse_rs  = d.tuse_rs;
    d_tuse_rt  = d.tuse_rt;
    d_a3       = d.a3;
    d_tnew     = d.tnew;
    d_md       = d.md;
    d_md_start = d.md_start;
    d_md_div   = d.md_div;
  endtask

  task automatic check_output(input string name, input dout_t want);
    dout_t act;
    act = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy};
    n_vec++;
    if (act !== want) begin
      n_miscompare++;
      $display("[TB] FAIL %s: got stall=%0b fd=%0d/%0d fe=%0d/%0d fm=%0d busy=%0b, expected stall=%0b fd=%0d/%0d fe=%0d/%0d fm=%0d busy=%0b",
               name, act.stall, act.fd_rs, act.fd_rt, act.fe_rs, act.fe_rt, act.fm_rt, act.busy,
               want.stall, want.fd_rs, want.fd_rt, want.fe_rs, want.fe_rt, want.fm_rt, want.busy);
    end
  endtask

  // Drive at posedge+1, check at negedge, advance the model at the next posedge.
  task automatic run_cycle(input din_t d, input dout_t want, input bit use_model, input string name);
    dout_t m;
    apply_stimulus(d);
    @(negedge clk);
    m = model_eval(d);
    check_output(name, use_model ? m : want);
    @(posedge clk);
    model_step(d, m.stall);
    #1;
  endtask

  // Asynchronous reset pulse in the middle of a cycle; everything must drop at once.
  task automatic reset_pulse_check(input string name);
    #2 reset = 1'b1;
    #1 check_output(name, '0);
    model_reset();
    #2 reset = 1'b0;
  endtask

  initial begin
    din_t d;

    tbl[0]  = mk(0, 0, 1, U, 1, 2,   0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 1, 3, 1,   1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 1, 1, 3, 1,   0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, U, U, 0, 0,   0, 0, 0, 3, 0, 0);
    tbl[4]  = mk(0, 0, U, U, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, U, U, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, U, U, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 1, 1, 2, 1,   0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(2, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(2, 0, 0, 0, 0, 0,   0, 2, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, U, U, 0, 0,   0, 0, 0, 3, 0, 0);
    tbl[11] = mk(0, 0, U, U, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, U, U, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, U, U, 31, 0,  0, 0, 0, 0, 0, 0);
    tbl[14] = mk(31, 0, 0, U, 0, 0,  0, 1, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, U, U, 0, 0,   0, 0, 0, 2, 0, 0);
    tbl[16] = mk(0, 0, U, U, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[17] = mk(0, 0, U, U, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, U, U, 0, 2,   0, 0, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[20] = mk(0, 0, U, U, 6, 0,   0, 0, 0, 0, 0, 0);
    tbl[21] = mk(0, 6, 1, 2, 0, 0,   0, 0, 1, 0, 0, 0);
    tbl[22] = mk(0, 0, U, U, 0, 0,   0, 0, 0, 0, 2, 0);
    tbl[23] = mk(0, 0, U, U, 0, 0,   0, 0, 0, 0, 0, 3);
    tbl[24] = mk(0, 0, U, U, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[25] = mk(0, 0, 1, U, 7, 2,   0, 0, 0, 0, 0, 0);
    tbl[26] = mk(0, 7, 1, 2, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[27] = mk(0, 0, U, U, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[28] = mk(0, 0, U, U, 0, 0,   0, 0, 0, 0, 0, 3);
    tbl[29] = mk(0, 0, U, U, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[30] = mk(0, 0, 1, U, 8, 2,   0, 0, 0, 0, 0, 0);
    tbl[31] = mk(0, 0, U, U, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[32] = mk(8, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    tbl[33] = mk(8, 0, 0, 0, 0, 0,   0, 3, 0, 0, 0, 0);
    tbl[34] = mk(0, 0, U, U, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[35] = mk(0, 0, U, U, 0, 0,   0, 0, 0, 0, 0, 0);

    model_reset();
    reset = 1'b1;
    apply_stimulus(mk_in(1, 2, 0, 0, 3, 0));
    #5 check_output("reset_state", '0);
    #10 reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 36; i++)
      run_cycle(tbl[i].d, tbl[i].e, 1'b0, $sformatf("vec[%0d]", i));

    $display("[TB] reset during stall and forwarding");
    run_cycle(mk_in(0, 0, U, U, 5, 0), '0, 1'b1, "rst_setup_jal");
    run_cycle(mk_in(0, 0, 1, U, 1, 2), '0, 1'b1, "rst_setup_lw");
    apply_stimulus(mk_in(1, 5, 1, 1, 3, 1));
    #1 check_output("rst_pre_pulse", mk_out(1, 0, 2, 0, 0, 0, 0));
    reset_pulse_check("rst_drop_stall");
    run_cycle(mk_in(1, 5, 1, 1, 3, 1), mk_out(0, 0, 0, 0, 0, 0, 0), 1'b0, "rst_resume");
    run_cycle(nop_in(), mk_out(0, 0, 0, 0, 0, 0, 0), 1'b0, "rst_resume_nop");

`ifdef HAZARD_MDU_EN
    $display("[TB] MDU busy sequences");
    run_cycle(md_in(1, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0), 1'b0, "mult_issue");
    for (int k = 1; k <= MULT_N; k++)
      run_cycle(md_in(0, 0, 9, 1), mk_out(1, 0, 0, 0, 0, 0, 1), 1'b0, $sformatf("mflo_wait%0d", k));
    run_cycle(md_in(0, 0, 9, 1), mk_out(0, 0, 0, 0, 0, 0, 0), 1'b0, "mflo_issue");
    run_cycle(md_in(1, 1, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0), 1'b0, "div_issue");
    for (int k = 1; k <= DIV_N; k++)
      run_cycle(md_in(0, 0, 9, 1), mk_out(1, 0, 0, 0, 0, 0, 1), 1'b0, $sformatf("div_wait%0d", k));
    run_cycle(md_in(0, 0, 9, 1), mk_out(0, 0, 0, 0, 0, 0, 0), 1'b0, "div_mflo_issue");
    run_cycle(md_in(1, 1, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0), 1'b0, "div2_issue");
    for (int k = 1; k <= 3; k++)
      run_cycle(md_in(0, 0, 9, 1), mk_out(1, 0, 0, 0, 0, 0, 1), 1'b0, $sformatf("div2_wait%0d", k));
    apply_stimulus(md_in(0, 0, 9, 1));
    reset_pulse_check("mdu_reset");
    run_cycle(md_in(0, 0, 9, 1), mk_out(0, 0, 0, 0, 0, 0, 0), 1'b0, "mdu_after_reset");
`else
    $display("[TB] MDU inputs ignored");
    run_cycle(md_in(1, 1, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0), 1'b0, "md_start_ignored");
    run_cycle(md_in(0, 0, 9, 1), mk_out(0, 0, 0, 0, 0, 0, 0), 1'b0, "md_read_ignored");
`endif
    run_cycle(nop_in(), '0, 1'b1, "flush0");
    run_cycle(nop_in(), '0, 1'b1, "flush1");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      int sel;
      d = '0;
      d.rs = 5'($urandom_range(0, 7));
      d.rt = 5'($urandom_range(0, 7));
      sel = $urandom_range(0, 3);
      d.tuse_rs = (sel == 3) ? 3'(U) : 3'(sel);
      sel = $urandom_range(0, 3);
      d.tuse_rt = (sel == 3) ? 3'(U) : 3'(sel);
      d.a3 = 5'($urandom_range(0, 7));
      d.tnew = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        d.md = 1'b1;
        d.md_start = 1'($urandom_range(0, 1));
        d.md_div = 1'($urandom_range(0, 1));
      end
      run_cycle(d, '0, 1'b1, $sformatf("rand[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
